// File: rtl/clk_divider_prog.sv
// Programmable multi-channel clock-enable/divider: each channel emits a one-cycle tick every D+1
// cycles and a 50%-duty clk_out of period 2*(D+1); divisor writes are double-buffered.
module clk_divider_prog #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out
);

  // Reset divisor for channel k is 2**k-1, saturating at all-ones when it does not fit.
  function automatic logic [CNT_W-1:0] dflt_div(input int k);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int b = 0; b < CNT_W; b++) begin
      if (b < k) v[b] = 1'b1;
    end
    return v;
  endfunction

  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] act     [N_CH];
  logic [CNT_W-1:0] shd     [N_CH];
  logic [CNT_W-1:0] shd_nxt [N_CH];
  logic [N_CH-1:0]  run;
  logic [N_CH-1:0]  term;
  logic             sel_ok;

  // div_we is a single-cycle strobe with no back-pressure: a write is taken on every edge where
  // div_we=1 and div_sel addresses an existing channel; out-of-range indices are dropped silently.
  always_comb begin
    sel_ok = (int'(div_sel) < N_CH);
    for (int k = 0; k < N_CH; k++) begin
      shd_nxt[k] = shd[k];
      if (div_we && sel_ok && (div_sel == SEL_W'(k))) shd_nxt[k] = div_val;
      run[k]  = en && ch_en[k];
      // ">=" lets a shrunk divisor terminate at once instead of wrapping through 2**CNT_W.
      term[k] = (cnt[k] >= act[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt[k]     <= '0;
        act[k]     <= dflt_div(k);
        shd[k]     <= dflt_div(k);
        tick[k]    <= 1'b0;
        clk_out[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        shd[k] <= shd_nxt[k];
        if (sync) begin
          cnt[k]     <= '0;
          tick[k]    <= 1'b0;
          clk_out[k] <= 1'b0;
          act[k]     <= shd_nxt[k];
        end else if (run[k]) begin
          if (term[k]) begin
            cnt[k]     <= '0;
            tick[k]    <= 1'b1;
            clk_out[k] <= ~clk_out[k];
            act[k]     <= shd_nxt[k];
          end else begin
            cnt[k]  <= cnt[k] + CNT_W'(1);
            tick[k] <= 1'b0;
          end
        end else begin
          // Held channels keep phase but pick up divisor changes immediately.
          tick[k] <= 1'b0;
          act[k]  <= shd_nxt[k];
        end
      end
    end
  end

endmodule
